// File: rtl/ex_lsu_pipe.sv
// ex_lsu_pipe: execute/memory stage.
//
// Purpose
//   Non-memory instructions retire one cycle after they are accepted, and
//   their ALU result is forwarded unchanged. A load or store is issued on a
//   req/gnt/rvalid data bus. While the stage is busy, ready_o is low and the
//   ID/EX register stalls. Store data is moved to its byte lane with matching
//   byte enables. Load data is taken from its lane and then sign- or
//   zero-extended. The writeback to the regfile is registered.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   valid_i / ready_o             ID/EX handshake
//   alu_sel_i, alu_result_i       writeback source select / ALU result
//   mem_addr_i, store_data_i      effective address / store value
//   rd_addr_i, rd_wr_en_i         destination register / write enable
//   lsu_req_i, lsu_we_i, lsu_type_i  memory op, store flag, funct3 size code
//   wb_valid_o, reg_we_o, wr_addr_o, rd_wdata_o   registered writeback
//   data_req_o .. data_rdata_i    data bus (req/gnt/rvalid)
//   err_o                         misalignment pulse (trap build only)
//
// Build option
//   MILANO_LSU_MISALIGN_TRAP_EN: when defined, a misaligned access is
//   trapped. It raises err_o and retires without a bus request. When the
//   macro is undefined, the byte offset is rounded down to the natural
//   alignment of the access.
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | ready for a new instruction
// WAIT_GNT    | request on the bus, fields held until grant
// WAIT_RVALID | load granted, waiting for read data

module ex_lsu_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              alu_sel_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_wr_en_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_type_i,
    output logic              wb_valid_o,
    output logic              reg_we_o,
    output logic [4:0]        wr_addr_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [BE_W-1:0]   data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic [DATA_W-1:0] data_rdata_i
`ifdef MILANO_LSU_MISALIGN_TRAP_EN
    ,
    output logic              err_o
`endif
);

    localparam int OFF_W = $clog2(BE_W);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_GNT    = 2'd1;
    localparam logic [1:0] WAIT_RVALID = 2'd2;

    logic [1:0]        state_q;

    // Request fields captured when the op is accepted
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [4:0]        rd_q;
    logic              rd_we_q;
    logic              alu_sel_q;
    logic [DATA_W-1:0] alu_q;

    // Writeback registers
    logic              wb_valid_q;
    logic              reg_we_q;
    logic [4:0]        wr_addr_q;
    logic [DATA_W-1:0] rd_wdata_q;

    // Decode of the incoming op
    logic [1:0]        size_d;
    logic [OFF_W-1:0]  off_d;
    logic [OFF_W-1:0]  mask_d;
    logic [OFF_W-1:0]  off_al_d;
    logic [BE_W-1:0]   be_base_d;
    logic [BE_W-1:0]   be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [ADDR_W-1:0] addr_al_d;

    // Load formatting
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        size_d = lsu_type_i[1:0];
        // A 32-bit datapath has no doubleword, so D is handled as W
        if (DATA_W == 32 && size_d == 2'b11) begin
            size_d = 2'b10;
        end
        off_d = mem_addr_i[OFF_W-1:0];
        case (size_d)
            2'b00: begin
                mask_d    = '0;
                be_base_d = BE_W'(8'h01);
            end
            2'b01: begin
                mask_d    = OFF_W'(3'd1);
                be_base_d = BE_W'(8'h03);
            end
            2'b10: begin
                mask_d    = OFF_W'(3'd3);
                be_base_d = BE_W'(8'h0F);
            end
            default: begin
                mask_d    = OFF_W'(3'd7);
                be_base_d = BE_W'(8'hFF);
            end
        endcase
        off_al_d  = off_d & ~mask_d;
        be_d      = be_base_d << off_al_d;
        wdata_d   = store_data_i << {off_al_d, 3'b000};
        addr_al_d = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

`ifdef MILANO_LSU_MISALIGN_TRAP_EN
    logic mis_d;
    logic err_q;
    assign mis_d = |(off_d & mask_d);
    assign err_o = err_q;
`endif

    // The OR-masks are all ones above the access size. For W on a 32-bit
    // datapath the mask is zero, so the word passes through unchanged.
    always_comb begin
        shifted = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00: begin
                load_data = DATA_W'(shifted[7:0]);
                if (!uns_q && shifted[7]) begin
                    load_data = load_data | ~DATA_W'(8'hFF);
                end
            end
            2'b01: begin
                load_data = DATA_W'(shifted[15:0]);
                if (!uns_q && shifted[15]) begin
                    load_data = load_data | ~DATA_W'(16'hFFFF);
                end
            end
            2'b10: begin
                load_data = DATA_W'(shifted[31:0]);
                if (!uns_q && shifted[31]) begin
                    load_data = load_data | ~DATA_W'(32'hFFFF_FFFF);
                end
            end
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            alu_sel_q  <= 1'b0;
            alu_q      <= '0;
            wb_valid_q <= 1'b0;
            reg_we_q   <= 1'b0;
            wr_addr_q  <= '0;
            rd_wdata_q <= '0;
`ifdef MILANO_LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef MILANO_LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (!lsu_req_i) begin
                            wb_valid_q <= 1'b1;
                            reg_we_q   <= rd_wr_en_i;
                            wr_addr_q  <= rd_addr_i;
                            rd_wdata_q <= alu_result_i;
`ifdef MILANO_LSU_MISALIGN_TRAP_EN
                        end else if (mis_d) begin
                            err_q      <= 1'b1;
                            wb_valid_q <= 1'b1;
                            reg_we_q   <= 1'b0;
                            wr_addr_q  <= rd_addr_i;
`endif
                        end else begin
                            addr_q    <= addr_al_d;
                            we_q      <= lsu_we_i;
                            be_q      <= be_d;
                            wdata_q   <= wdata_d;
                            off_q     <= off_al_d;
                            size_q    <= size_d;
                            uns_q     <= lsu_type_i[2];
                            rd_q      <= rd_addr_i;
                            rd_we_q   <= rd_wr_en_i;
                            alu_sel_q <= alu_sel_i;
                            alu_q     <= alu_result_i;
                            state_q   <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) begin
                        if (we_q) begin
                            wb_valid_q <= 1'b1;
                            reg_we_q   <= 1'b0;
                            wr_addr_q  <= rd_q;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= WAIT_RVALID;
                        end
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        wb_valid_q <= 1'b1;
                        reg_we_q   <= rd_we_q;
                        wr_addr_q  <= rd_q;
                        rd_wdata_q <= alu_sel_q ? alu_q : load_data;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign data_req_o   = (state_q == WAIT_GNT);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign reg_we_o     = reg_we_q;
    assign wr_addr_o    = wr_addr_q;
    assign rd_wdata_o   = rd_wdata_q;

endmodule
